// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch widths, DONE opcode, branch conditions and
// fetch sequencer states.
package cpu_pkg;

  localparam int PC_W  = 9;
  localparam int OFF_W = 15;
  localparam int CNT_W = 16;

  localparam logic [4:0] OP_DONE = 5'b01110;

  typedef enum logic [1:0] {
    BR_ALWAYS = 2'b00,
    BR_EQ     = 2'b01,
    BR_LT     = 2'b10,
    BR_GT     = 2'b11
  } br_cond_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Sign-extension followed by truncation to PC_W is the same as adding the
  // low PC_W bits of the offset modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_rel(input logic [PC_W-1:0]  pc,
                                             input logic [OFF_W-1:0] off);
    return pc + off[PC_W-1:0];
  endfunction

endpackage

// File: rtl/pc_fetch_cond_flags.sv
// Compare-flag register and branch condition evaluation. The condition is
// computed from the registered flags, so a same-cycle flag write is seen next cycle.
module cond_flags
  import cpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we_i,
  input  logic     eq_i,
  input  logic     lt_i,
  input  logic     gt_i,
  input  br_cond_t cond_i,
  output logic     cond_true_o
);

  logic eqQ, ltQ, gtQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eqQ <= 1'b0;
      ltQ <= 1'b0;
      gtQ <= 1'b0;
    end else if (we_i) begin
      eqQ <= eq_i;
      ltQ <= lt_i;
      gtQ <= gt_i;
    end
  end

  always_comb begin
    cond_true_o = 1'b0;
    unique case (cond_i)
      BR_ALWAYS: cond_true_o = 1'b1;
      BR_EQ:     cond_true_o = eqQ;
      BR_LT:     cond_true_o = ltQ;
      BR_GT:     cond_true_o = gtQ;
      default:   cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter / fetch sequencer: drives the instruction ROM address,
// resolves PC-relative branches and sequences start / run / done per kernel.
module pc_fetch
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_en,
  input  logic [1:0]       br_cond,
  input  logic [OFF_W-1:0] br_off,
  input  logic             flag_we,
  input  logic             flag_eq,
  input  logic             flag_lt,
  input  logic             flag_gt,
  output logic [PC_W-1:0]  iptr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  iptr_q;
  logic [PC_W-1:0]  iptr_d;
  logic             done_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] cycles_d;
  logic             advance;
  logic             condTrue;

  assign advance = (state_q == RUN) && !stall;

  cond_flags u_cond_flags (
    .clk         (clk),
    .rst_n       (rst_n),
    .we_i        (advance && flag_we),
    .eq_i        (flag_eq),
    .lt_i        (flag_lt),
    .gt_i        (flag_gt),
    .cond_i      (br_cond_t'(br_cond)),
    .cond_true_o (condTrue)
  );

  // Next fetch address for a non-stalled RUN cycle: halt > branch > increment.
  always_comb begin
    iptr_d = iptr_q + 1'b1;
    if (halt) begin
      iptr_d = '0;
    end else if (br_en && condTrue) begin
      iptr_d = pc_rel(iptr_q, br_off);
    end
  end

  assign cycles_d = (cycles_q == {CNT_W{1'b1}}) ? cycles_q : cycles_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      iptr_q   <= '0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          iptr_q <= '0;
          if (start) begin
            state_q  <= RUN;
            iptr_q   <= start_addr;
            cycles_q <= '0;
          end
        end
        RUN: begin
          // Stall cycles still count towards the kernel's run time.
          cycles_q <= cycles_d;
          if (!stall) begin
            iptr_q <= iptr_d;
            if (halt) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          iptr_q  <= '0;
        end
      endcase
    end
  end

  assign iptr   = iptr_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Scoreboard bench for pc_fetch: a behavioural model predicts each cycle's
// outputs into a queue, and a monitor compares them against the DUT.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [8:0]  start_addr;
  logic        stall;
  logic        halt;
  logic        br_en;
  logic [1:0]  br_cond;
  logic [14:0] br_off;
  logic        flag_we;
  logic        flag_eq;
  logic        flag_lt;
  logic        flag_gt;
  logic [8:0]  iptr;
  logic        busy;
  logic        done;
  logic [15:0] cycles;

  typedef struct {
    int iptr;
    int busy;
    int done;
    int cycles;
  } exp_t;

  exp_t expQ[$];
  int   totalChecks;
  int   badChecks;

  // Reference model state
  bit mRun;
  int mPc;
  bit mEq, mLt, mGt;
  int mCycles;
  bit mDone;

  pc_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .halt       (halt),
    .br_en      (br_en),
    .br_cond    (br_cond),
    .br_off     (br_off),
    .flag_we    (flag_we),
    .flag_eq    (flag_eq),
    .flag_lt    (flag_lt),
    .flag_gt    (flag_gt),
    .iptr       (iptr),
    .busy       (busy),
    .done       (done),
    .cycles     (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, actual, actual, expected, expected, $time);
    end
  endtask

  // Model one clock edge from the specification's rules using plain integers.
  task automatic modelStep();
    int off;
    bit take;
    if (!rst_n) begin
      mRun = 0; mPc = 0; mEq = 0; mLt = 0; mGt = 0; mCycles = 0; mDone = 0;
      return;
    end
    mDone = 0;
    if (!mRun) begin
      mPc = 0;
      if (start) begin
        mRun = 1;
        mPc = start_addr;
        mCycles = 0;
      end
      return;
    end
    if (mCycles < 65535) mCycles = mCycles + 1;
    if (stall) return;
    take = (br_cond == 2'd0) || (br_cond == 2'd1 && mEq) ||
           (br_cond == 2'd2 && mLt) || (br_cond == 2'd3 && mGt);
    off = (br_off >= 15'd16384) ? int'(br_off) - 32768 : int'(br_off);
    if (halt) begin
      mRun = 0;
      mPc = 0;
      mDone = 1;
    end else if (br_en && take) begin
      mPc = (((mPc + off) % 512) + 512) % 512;
    end else begin
      mPc = (mPc + 1) % 512;
    end
    if (flag_we) begin
      mEq = flag_eq; mLt = flag_lt; mGt = flag_gt;
    end
  endtask

  task automatic applyStimulus(input bit rstn, input bit st, input int sa,
                               input bit stl, input bit hlt, input bit be,
                               input int bc, input int bo, input bit fwe,
                               input bit feq, input bit flt, input bit fgt);
    exp_t e;
    @(negedge clk);
    rst_n      = rstn;
    start      = st;
    start_addr = sa[8:0];
    stall      = stl;
    halt       = hlt;
    br_en      = be;
    br_cond    = bc[1:0];
    br_off     = bo[14:0];
    flag_we    = fwe;
    flag_eq    = feq;
    flag_lt    = flt;
    flag_gt    = fgt;
    modelStep();
    e.iptr = mPc; e.busy = mRun; e.done = mDone; e.cycles = mCycles;
    expQ.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic startAt(input int addr);
    applyStimulus(1, 1, addr, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic haltNow();
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT against the oldest prediction after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("iptr",   int'(iptr),   e.iptr);
        checkOutput("busy",   int'(busy),   e.busy);
        checkOutput("done",   int'(done),   e.done);
        checkOutput("cycles", int'(cycles), e.cycles);
      end
    end
  end

  initial begin
    int waitCount;
    totalChecks = 0;
    badChecks   = 0;
    rst_n = 1'b0; start = 0; start_addr = '0; stall = 0; halt = 0;
    br_en = 0; br_cond = '0; br_off = '0; flag_we = 0;
    flag_eq = 0; flag_lt = 0; flag_gt = 0;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycle();

    // Start at 1, three clean increments
    startAt(1);
    repeat (3) idleCycle();
    haltNow();
    idleCycle();

    // Backward lt branch from 0x010 by -13
    startAt(15);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 2, 15'h7FF3, 0, 0, 0, 0);
    haltNow();

    // eq branch not taken then taken from 0x005
    startAt(4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
    haltNow();
    startAt(4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0);
    haltNow();

    // Wrap forward past 0x1FF, then branch -1 from 0x000
    startAt(9'h1FF);
    idleCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 15'h7FFF, 0, 0, 0, 0);
    haltNow();

    // Stall with a pending branch and flag write, then release
    startAt(9'h02A);
    repeat (3) applyStimulus(1, 0, 0, 1, 0, 1, 0, 100, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) idleCycle();

    // Halt with done pulse, start at 0x03B
    startAt(9'h03B);
    haltNow();
    repeat (3) idleCycle();

    // Reset in the middle of a run
    startAt(9'h100);
    repeat (4) idleCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 97) != 0,
                    ($urandom % 6) == 0,
                    int'($urandom % 512),
                    ($urandom % 5) == 0,
                    ($urandom % 18) == 0,
                    ($urandom % 3) == 0,
                    int'($urandom % 4),
                    (($urandom % 2) == 0) ? int'($urandom % 32768)
                                          : int'(($urandom % 32) + 32752),
                    ($urandom % 2) == 0,
                    ($urandom % 2) == 0,
                    ($urandom % 2) == 0,
                    ($urandom % 2) == 0);
    end
    idleCycle();

    waitCount = 0;
    while (expQ.size() > 0 && waitCount < 20) begin
      @(posedge clk);
      waitCount++;
    end
    #2;
    if (expQ.size() > 0) begin
      badChecks++;
      $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
